// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between two requesters with a held response
//
// Purpose:
//   Accepts one operation at a time from either of two requesters, registers
//   the operands onto the shared ALU inputs, captures the ALU result and zero
//   flag one cycle later, and holds that response until the consumer takes it.
//   Ties are broken round-robin. Defining ALU_ARB_FIXED_PRIORITY_EN makes
//   port 0 always win a tie instead.
//
// Ports:
//   clk, rst_n                    clock (rising edge), synchronous active-low reset
//   reqN_valid/ready/a/b/op       request ports 0 and 1 (op: 00 add, 01 xor, 10 pass B, 11 A-B)
//   alu_a, alu_b, alu_op          registered operands driven to the shared ALU
//   alu_result, alu_zero          combinational ALU outputs
//   rsp_valid/ready/data/zero/id  held response and the requester that issued it
//   busy                          high whenever the sequencer is not idle
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [1:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [1:0]            req1_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_zero,
  output logic                  rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]            alu_op_q, alu_op_d;
  logic                  gnt_id_q, gnt_id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic                  rsp_id_q, rsp_id_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
  logic                  last_grant_q, last_grant_d;
`endif

  logic grant_valid;
  logic grant_port;

  // Grant is only offered in IDLE, so the response handshake never feeds
  // back into request acceptance.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        grant_port  = 1'b0;
`else
        grant_port  = ~last_grant_q;
`endif
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid & ~grant_port;
  assign req1_ready = grant_valid &  grant_port;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    gnt_id_d     = gnt_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_id_d     = rsp_id_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          alu_a_d      = grant_port ? req1_a  : req0_a;
          alu_b_d      = grant_port ? req1_b  : req0_b;
          alu_op_d     = grant_port ? req1_op : req0_op;
          gnt_id_d     = grant_port;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
          last_grant_d = grant_port;
`endif
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // Operands have been stable on the ALU for a full cycle here.
        rsp_data_d  = alu_result;
        rsp_zero_d  = alu_zero;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 2'b00;
      gnt_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      // Pretend port 1 went last so port 0 wins the first tie.
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      gnt_id_q     <= gnt_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter
//
// Purpose:
//   Drives both request ports, models the shared ALU, and compares responses,
//   latency, arbitration order, backpressure and mid-operation reset against
//   hand-computed values. Honours ALU_ARB_FIXED_PRIORITY_EN for the tie order.
//
// Ports: none (top-level bench).
module tb_alu_share_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;
  logic         alu_zero;
  logic         rsp_valid, rsp_zero, rsp_id, busy;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .busy(busy)
  );

  // Reference model of the attached ALU.
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a ^ alu_b;
      2'b10:   alu_result = alu_b;
      default: alu_result = alu_a - alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_data;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic port, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] op);
    if (port) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // One full operation on `port`; with `other` set the other port also
  // requests, and `port` is still expected to be the one granted.
  task automatic do_op(input logic port, input logic other, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] op,
                       input logic [W-1:0] exp_data, input logic exp_zero);
    bit granted = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(port, 1'b1, a, b, op);
    if (other) drive_req(~port, 1'b1, ~a, ~b, ~op);
    for (int i = 0; i < 8; i++) begin
      #1;
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        granted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!granted) begin
      check("grant_timeout", 32'd0, 32'd1);
      drive_req(0, 1'b0, '0, '0, 2'b00);
      drive_req(1, 1'b0, '0, '0, 2'b00);
      return;
    end
    check("other_ready_low", port ? req0_ready : req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_req(0, 1'b0, '0, '0, 2'b00);
    drive_req(1, 1'b0, '0, '0, 2'b00);
    check("exec_rsp_valid", rsp_valid, 1'b0);
    check("exec_busy", busy, 1'b1);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, op);
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_zero", rsp_zero, exp_zero);
    check("rsp_id", rsp_id, port);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] held;
    logic         exp_ids[4];
    logic         got_ids[4];
    int           got;
    bit           both_ready;
    bit           pulse;

    vecs[0] = '{1'b0, 16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0005, 2'b11, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 16'h0000, 16'h0001, 2'b11, 16'hFFFF, 1'b0};
    vecs[3] = '{1'b0, 16'hAAAA, 16'hFFFF, 2'b01, 16'h5555, 1'b0};
    vecs[4] = '{1'b0, 16'hAAAA, 16'hFFFF, 2'b10, 16'hFFFF, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_alu_a", alu_a, 16'h0000);
    check("rst_alu_b", alu_b, 16'h0000);
    check("rst_alu_op", alu_op, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    rst_n = 1'b1;

    // Table-driven single operations
    foreach (vecs[i])
      do_op(vecs[i].port, 1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_data, vecs[i].exp_zero);

    // Backpressure: response held for 5 cycles while both ports request
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(0, 1'b1, 16'h1234, 16'h0001, 2'b00);
    #1;
    check("bp_req0_ready", req0_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_req(0, 1'b0, '0, '0, 2'b00);
    @(negedge clk);
    held = 16'h1235;
    drive_req(0, 1'b1, 16'h0001, 16'h0001, 2'b00);
    drive_req(1, 1'b1, 16'h0002, 16'h0002, 2'b00);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_data", rsp_data, held);
      check("bp_ready0", req0_ready, 1'b0);
      check("bp_ready1", req1_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready0_rspready", req0_ready, 1'b0);
    check("bp_ready1_rspready", req1_ready, 1'b0);
    @(negedge clk);
    check("bp_idle_busy", busy, 1'b0);
    check("bp_idle_rsp_valid", rsp_valid, 1'b0);
    drive_req(0, 1'b0, '0, '0, 2'b00);
    drive_req(1, 1'b0, '0, '0, 2'b00);

    // Contention from a clean reset
    do_reset();
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    got = 0;
    both_ready = 0;
    drive_req(0, 1'b1, 16'h0001, 16'h0002, 2'b00);
    drive_req(1, 1'b1, 16'h000A, 16'h0001, 2'b11);
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (req0_ready && req1_ready) both_ready = 1;
      if (rsp_valid) begin
        got_ids[got] = rsp_id;
        check("cont_data", rsp_data, exp_ids[got] ? 16'h0009 : 16'h0003);
        got++;
      end
    end
    drive_req(0, 1'b0, '0, '0, 2'b00);
    drive_req(1, 1'b0, '0, '0, 2'b00);
    check("cont_count", got, 4);
    check("cont_one_hot_ready", both_ready, 1'b0);
    for (int i = 0; i < 4 && i < got; i++)
      check("cont_rsp_id", got_ids[i], exp_ids[i]);
    repeat (3) @(negedge clk);

    // Reset while in EXEC discards the operation
    drive_req(1, 1'b1, 16'h0005, 16'h0005, 2'b11);
    #1;
    check("rx_req1_ready", req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 1'b0, '0, '0, 2'b00);
    check("rx_in_exec", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rx_rsp_valid", rsp_valid, 1'b0);
    check("rx_busy", busy, 1'b0);
    check("rx_alu_a", alu_a, 16'h0000);
    check("rx_alu_b", alu_b, 16'h0000);
    check("rx_alu_op", alu_op, 2'b00);
    check("rx_rsp_data", rsp_data, 16'h0000);
    check("rx_rsp_zero", rsp_zero, 1'b0);
    check("rx_rsp_id", rsp_id, 1'b0);
    rst_n = 1'b1;
    pulse = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) pulse = 1;
    end
    check("rx_no_rsp_pulse", pulse, 1'b0);

    // First tie after reset goes to port 0 in either arbitration mode
    do_op(1'b0, 1'b1, 16'h0010, 16'h0020, 2'b00, 16'h0030, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1);
  end

endmodule
